// File: rtl/conv_pkg.sv
// Shared types and defaults for the conv PIM job scheduler.
// Holds the scheduler state enum, parameter defaults and a sign-extend helper.
package conv_pkg;

  localparam int CONV_INPUT_SIZE = 34;
  localparam int CONV_DEPTH      = 6;
  localparam int CONV_ADC_P      = 8;
  localparam int CONV_PIM_LAT    = 1;
  localparam int CONV_ACC_W      = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } conv_sched_state_t;

  // Replicates bit w-1 of v into every bit above it; callers keep w in 1..63.
  function automatic logic [63:0] sign_extend(input logic [63:0] v, input int unsigned w);
    logic [63:0] keep;
    keep = ~({64{1'b1}} << w);
    return v[6'(w - 1)] ? (v | ~keep) : (v & keep);
  endfunction

endpackage

// File: rtl/conv_sched_if.sv
// Job, result and crossbar-array signals of the conv scheduler, bundled as one interface.
// slave is the scheduler's view; master is the sequencer/array/testbench view.
interface conv_sched_if
  import conv_pkg::*;
#(
  parameter int INPUT_SIZE = CONV_INPUT_SIZE,
  parameter int DEPTH      = CONV_DEPTH,
  parameter int ADC_P      = CONV_ADC_P,
  parameter int ACC_W      = CONV_ACC_W
);

  logic                  job_valid;
  logic                  job_ready;
  logic [INPUT_SIZE-1:0] job_feature;
  logic [DEPTH-1:0]      job_base;
  logic [DEPTH:0]        job_count;

  logic                  res_valid;
  logic                  res_ready;
  logic [ACC_W-1:0]      res_data;
  logic                  res_ovf;

  logic                  pim_en;
  logic [DEPTH-1:0]      pim_addr;
  logic [INPUT_SIZE-1:0] pim_feature;
  logic [ADC_P-1:0]      pim_out;

  logic                  busy;

  modport slave (
    input  job_valid, job_feature, job_base, job_count, res_ready, pim_out,
    output job_ready, res_valid, res_data, res_ovf, pim_en, pim_addr, pim_feature, busy
  );

  modport master (
    output job_valid, job_feature, job_base, job_count, res_ready, pim_out,
    input  job_ready, res_valid, res_data, res_ovf, pim_en, pim_addr, pim_feature, busy
  );

endinterface

// File: rtl/conv_sched_acc.sv
// Signed accumulator with clear, add-enable and a sticky overflow flag.
// Define CONV_SCHED_SAT_EN to saturate on overflow; otherwise the sum wraps.
module conv_sched_acc
  import conv_pkg::*;
#(
  parameter int ADC_P = CONV_ADC_P,
  parameter int ACC_W = CONV_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             add_i,
  input  logic [ADC_P-1:0] din_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             ovf_o
);

  logic [ACC_W-1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   wide;
  logic             clip;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sum_d = sum_q;
    ovf_d = ovf_q;
    // One guard bit above the sum: overflow shows as the top two bits disagreeing.
    wide  = {sum_q[ACC_W-1], sum_q} + (ACC_W + 1)'(sign_extend(64'(din_i), ADC_P));
    clip  = wide[ACC_W] ^ wide[ACC_W-1];
    if (clr_i) begin
      sum_d = '0;
      ovf_d = 1'b0;
    end else if (add_i) begin
      ovf_d = ovf_q | clip;
`ifdef CONV_SCHED_SAT_EN
      if (clip) begin
        sum_d = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
        sum_d = wide[ACC_W-1:0];
      end
`else
      sum_d = wide[ACC_W-1:0];
`endif
    end
  end

  // NOTE: sequential state is written only with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      ovf_q <= ovf_d;
    end
  end

  assign sum_o = sum_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/conv_sched.sv
// Job scheduler for the conv PIM crossbar: issues one row address per cycle and sums the ADC results.
// Overflow behaviour of the sum is selected by CONV_SCHED_SAT_EN inside conv_sched_acc.
module conv_sched
  import conv_pkg::*;
#(
  parameter int INPUT_SIZE = CONV_INPUT_SIZE,
  parameter int DEPTH      = CONV_DEPTH,
  parameter int ADC_P      = CONV_ADC_P,
  parameter int PIM_LAT    = CONV_PIM_LAT,
  parameter int ACC_W      = CONV_ACC_W
) (
  input logic         clk,
  input logic         rst,
  conv_sched_if.slave bus
);

  // Delay-line pattern when only the final issue is still in flight.
  localparam logic [PIM_LAT-1:0] LAST_ONLY = PIM_LAT'(1) << (PIM_LAT - 1);

  conv_sched_state_t     state_q, state_d;
  logic [INPUT_SIZE-1:0] feature_q, feature_d;
  logic [DEPTH-1:0]      addr_q, addr_d;
  logic [DEPTH:0]        cnt_q, cnt_d;
  logic [PIM_LAT-1:0]    dly_q, dly_d;
  logic                  issue;
  logic                  sample;
  logic                  last_sample;
  logic                  acc_clr;

  assign issue       = (state_q == ISSUE);
  assign sample      = dly_q[PIM_LAT-1];
  assign last_sample = (state_q == DRAIN) && (dly_q == LAST_ONLY);
  assign dly_d       = PIM_LAT'({dly_q, issue});

  always_comb begin
    state_d   = state_q;
    feature_d = feature_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    acc_clr   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.job_valid) begin
          feature_d = bus.job_feature;
          addr_d    = bus.job_base;
          cnt_d     = bus.job_count;
          acc_clr   = 1'b1;
          state_d   = (bus.job_count == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        cnt_d = cnt_q - 1'b1;
        // The last issued address stays on pim_addr through DRAIN.
        if (cnt_q == 1) begin
          state_d = DRAIN;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      DRAIN: begin
        if (last_sample) state_d = DONE;
      end
      DONE: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      feature_q <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      dly_q     <= '0;
    end else begin
      state_q   <= state_d;
      feature_q <= feature_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      dly_q     <= dly_d;
    end
  end

  conv_sched_acc #(
    .ADC_P (ADC_P),
    .ACC_W (ACC_W)
  ) u_acc (
    .clk   (clk),
    .rst   (rst),
    .clr_i (acc_clr),
    .add_i (sample),
    .din_i (bus.pim_out),
    .sum_o (bus.res_data),
    .ovf_o (bus.res_ovf)
  );

  assign bus.job_ready   = (state_q == IDLE);
  assign bus.res_valid   = (state_q == DONE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.pim_en      = issue;
  assign bus.pim_addr    = addr_q;
  assign bus.pim_feature = feature_q;

endmodule

// File: tb/tb_conv_sched.sv
// Self-checking bench for conv_sched: a default instance (ACC_W=16, PIM_LAT=1) and a narrow one (ACC_W=8, PIM_LAT=3).
// Expected sums come from a per-row arithmetic model over the bench's own crossbar contents.
module tb_conv_sched;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  bit          sel           = 1'b0;
  logic        job_valid_drv = 1'b0;
  logic        res_ready_drv = 1'b0;
  logic [33:0] feat_drv      = '0;
  logic [5:0]  base_drv      = '0;
  logic [6:0]  count_drv     = '0;

  conv_sched_if                 if_a ();
  conv_sched_if #(.ACC_W(8))    if_b ();

  assign if_a.job_valid   = job_valid_drv & ~sel;
  assign if_a.res_ready   = res_ready_drv & ~sel;
  assign if_a.job_feature = feat_drv;
  assign if_a.job_base    = base_drv;
  assign if_a.job_count   = count_drv;
  assign if_b.job_valid   = job_valid_drv & sel;
  assign if_b.res_ready   = res_ready_drv & sel;
  assign if_b.job_feature = feat_drv;
  assign if_b.job_base    = base_drv;
  assign if_b.job_count   = count_drv;

  conv_sched dut_a (.clk(clk), .rst(rst), .bus(if_a));
  conv_sched #(.PIM_LAT(3), .ACC_W(8)) dut_b (.clk(clk), .rst(rst), .bus(if_b));

  // Crossbar array model: row contents plus a pipeline of the array latency; junk when not valid.
  logic signed [7:0] rom [64];
  logic [7:0]        junk = 8'h00;
  always @(posedge clk) junk <= 8'($urandom);

  logic       a_v    = 1'b0;
  logic [5:0] a_addr = '0;
  always @(posedge clk) begin
    a_v    <= if_a.pim_en;
    a_addr <= if_a.pim_addr;
  end
  assign if_a.pim_out = a_v ? rom[a_addr] : junk;

  logic       b_v    [3] = '{1'b0, 1'b0, 1'b0};
  logic [5:0] b_addr [3] = '{6'd0, 6'd0, 6'd0};
  always @(posedge clk) begin
    b_v[0]    <= if_b.pim_en;
    b_addr[0] <= if_b.pim_addr;
    for (int i = 1; i < 3; i++) begin
      b_v[i]    <= b_v[i-1];
      b_addr[i] <= b_addr[i-1];
    end
  end
  assign if_b.pim_out = b_v[2] ? rom[b_addr[2]] : junk;

  // Observation of whichever instance is selected; the narrow sum is sign-extended to 16 bits.
  logic        obs_job_ready, obs_res_valid, obs_res_ovf, obs_pim_en, obs_busy;
  logic [15:0] obs_res_data;
  logic [5:0]  obs_pim_addr;
  logic [33:0] obs_pim_feature;
  logic [60:0] obs_vec;
  assign obs_job_ready   = sel ? if_b.job_ready   : if_a.job_ready;
  assign obs_res_valid   = sel ? if_b.res_valid   : if_a.res_valid;
  assign obs_res_ovf     = sel ? if_b.res_ovf     : if_a.res_ovf;
  assign obs_pim_en      = sel ? if_b.pim_en      : if_a.pim_en;
  assign obs_busy        = sel ? if_b.busy        : if_a.busy;
  assign obs_pim_addr    = sel ? if_b.pim_addr    : if_a.pim_addr;
  assign obs_pim_feature = sel ? if_b.pim_feature : if_a.pim_feature;
  assign obs_res_data    = sel ? {{8{if_b.res_data[7]}}, if_b.res_data} : if_a.res_data;
  assign obs_vec = {obs_job_ready, obs_res_valid, obs_res_data, obs_res_ovf,
                    obs_pim_en, obs_pim_addr, obs_pim_feature, obs_busy};

  localparam logic [60:0] RESET_VEC = 61'(1) << 60;

  // Reference: walk the rows, add each value, then wrap or clip into a w-bit signed range.
  function automatic void model(input int base, input int cnt, input int w,
                                output logic [15:0] res, output logic ovf);
    longint acc = 0;
    longint hi  = (longint'(1) << (w - 1)) - 1;
    longint lo  = -(longint'(1) << (w - 1));
    ovf = 1'b0;
    for (int k = 0; k < cnt; k++) begin
      acc += rom[(base + k) % 64];
      if (acc > hi || acc < lo) begin
        ovf = 1'b1;
`ifdef CONV_SCHED_SAT_EN
        acc = (acc > hi) ? hi : lo;
`else
        acc = (acc > hi) ? acc - (longint'(1) << w) : acc + (longint'(1) << w);
`endif
      end
    end
    res = 16'(acc);
  endfunction

  function automatic logic [33:0] rand_feat();
    return {2'($urandom), 32'($urandom)};
  endfunction

  task automatic fill_rand();
    for (int a = 0; a < 64; a++) rom[a] = 8'($urandom);
  endtask

  // Runs one job on the selected instance; entered and left on a falling edge.
  task automatic run_job(input string tag, input int base, input int cnt, input logic [33:0] feat,
                         input int stall, input bit chain, input int nbase, input int ncnt,
                         input logic [33:0] nfeat, output int waited);
    logic [15:0] exp_data;
    logic        exp_ovf;
    int          lat, t, r, k;
    lat = sel ? 3 : 1;
    model(base, cnt, sel ? 8 : 16, exp_data, exp_ovf);
    base_drv      = 6'(base);
    count_drv     = 7'(cnt);
    feat_drv      = feat;
    job_valid_drv = 1'b1;
    waited        = 0;
    while (!obs_job_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    n_total++;
    if (obs_job_ready !== 1'b1) begin
      $display("FAIL %s accept: job_ready=%b after 200 cycles, required 1", tag, obs_job_ready);
      job_valid_drv = 1'b0;
      return;
    end
    n_pass++;
    t = cyc;
    @(negedge clk);
    if (chain) begin
      base_drv  = 6'(nbase);
      count_drv = 7'(ncnt);
      feat_drv  = nfeat;
    end else begin
      job_valid_drv = 1'b0;
      base_drv      = 6'($urandom);
      count_drv     = 7'($urandom);
      feat_drv      = rand_feat();
    end
    k = 0;
    r = -1;
    for (int i = 0; i < 300; i++) begin
      if (obs_res_valid) begin
        r = cyc;
        break;
      end
      if (obs_pim_en) begin
        n_total++;
        if (obs_pim_addr !== 6'((base + k) % 64) || obs_pim_feature !== feat || cyc != t + 1 + k)
          $display("FAIL %s issue%0d: addr=%0d feat=%h cycle=+%0d, required addr=%0d feat=%h cycle=+%0d",
                   tag, k, obs_pim_addr, obs_pim_feature, cyc - t, (base + k) % 64, feat, 1 + k);
        else n_pass++;
        k++;
      end
      @(negedge clk);
    end
    n_total++;
    if (k != cnt) $display("FAIL %s issue_count: got %0d, required %0d", tag, k, cnt);
    else n_pass++;
    n_total++;
    if (r < 0 || r - t != ((cnt == 0) ? 1 : cnt + lat + 1))
      $display("FAIL %s latency: got %0d, required %0d", tag, (r < 0) ? -1 : r - t,
               (cnt == 0) ? 1 : cnt + lat + 1);
    else n_pass++;
    n_total++;
    if (obs_res_data !== exp_data || obs_res_ovf !== exp_ovf)
      $display("FAIL %s result: data=%h ovf=%b, required data=%h ovf=%b",
               tag, obs_res_data, obs_res_ovf, exp_data, exp_ovf);
    else n_pass++;
    if (r < 0) return;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      n_total++;
      if (obs_res_valid !== 1'b1 || obs_res_data !== exp_data || obs_res_ovf !== exp_ovf || obs_job_ready !== 1'b0)
        $display("FAIL %s stall%0d: valid=%b data=%h ovf=%b job_ready=%b, required 1 %h %b 0",
                 tag, s, obs_res_valid, obs_res_data, obs_res_ovf, obs_job_ready, exp_data, exp_ovf);
      else n_pass++;
    end
    res_ready_drv = 1'b1;
    @(negedge clk);
    res_ready_drv = 1'b0;
    n_total++;
    if (obs_res_valid !== 1'b0 || obs_job_ready !== 1'b1 || obs_busy !== 1'b0)
      $display("FAIL %s after_handshake: valid=%b job_ready=%b busy=%b, required 0 1 0",
               tag, obs_res_valid, obs_job_ready, obs_busy);
    else n_pass++;
  endtask

  task automatic test_reset();
    sel = 1'b0;
    n_total++;
    if (obs_vec !== RESET_VEC) $display("FAIL reset_values: got %h, required %h", obs_vec, RESET_VEC);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int w;
    for (int a = 0; a < 64; a++) rom[a] = 8'(2 * a);
    run_job("basic", 3, 4, rand_feat(), 0, 1'b0, 0, 0, '0, w);
  endtask

  task automatic test_wrap_negative();
    int w;
    for (int a = 0; a < 64; a++) rom[a] = -8'sd1;
    run_job("wrap", 62, 4, rand_feat(), 0, 1'b0, 0, 0, '0, w);
  endtask

  task automatic test_count_zero();
    int w;
    fill_rand();
    run_job("count0", int'($urandom_range(0, 63)), 0, rand_feat(), 0, 1'b0, 0, 0, '0, w);
  endtask

  task automatic test_back_to_back();
    int          w, b2, c2;
    logic [33:0] f2;
    fill_rand();
    b2 = int'($urandom_range(0, 63));
    c2 = int'($urandom_range(1, 12));
    f2 = rand_feat();
    run_job("bp_first", int'($urandom_range(0, 63)), 5, rand_feat(), 5, 1'b1, b2, c2, f2, w);
    run_job("bp_second", b2, c2, f2, 0, 1'b0, 0, 0, '0, w);
    n_total++;
    if (w != 0) $display("FAIL bp_accept_delay: waited %0d cycles, required 0", w);
    else n_pass++;
  endtask

  task automatic test_reset_mid_issue();
    int          b, i, w;
    bit          seen;
    logic [33:0] f;
    sel = 1'b0;
    fill_rand();
    b = int'($urandom_range(0, 63));
    f = rand_feat();
    base_drv      = 6'(b);
    count_drv     = 7'd8;
    feat_drv      = f;
    job_valid_drv = 1'b1;
    i = 0;
    while (!obs_job_ready && i < 50) begin
      @(negedge clk);
      i++;
    end
    @(negedge clk);
    job_valid_drv = 1'b0;
    i = 0;
    while (!(obs_pim_en && obs_pim_addr == 6'((b + 2) % 64)) && i < 20) begin
      @(negedge clk);
      i++;
    end
    n_total++;
    if (i >= 20) $display("FAIL rst_mid reach_k2: addr=%0d pim_en=%b, required addr=%0d pim_en=1",
                          obs_pim_addr, obs_pim_en, (b + 2) % 64);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_total++;
    if (obs_vec !== RESET_VEC) $display("FAIL rst_mid values: got %h, required %h", obs_vec, RESET_VEC);
    else n_pass++;
    @(negedge clk);
    rst  = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (obs_res_valid || obs_pim_en) seen = 1'b1;
    end
    n_total++;
    if (seen) $display("FAIL rst_mid quiet: res_valid/pim_en rose after release, required 0");
    else n_pass++;
    run_job("after_reset", int'($urandom_range(0, 63)), 8, rand_feat(), 0, 1'b0, 0, 0, '0, w);
  endtask

  task automatic test_overflow();
    int w;
    sel = 1'b1;
    for (int a = 0; a < 64; a++) rom[a] = 8'sd127;
    run_job("ovf127x3", 0, 3, rand_feat(), 0, 1'b0, 0, 0, '0, w);
    for (int j = 0; j < 4; j++) begin
      fill_rand();
      run_job($sformatf("narrow_rand%0d", j), int'($urandom_range(0, 63)),
              (j == 0) ? 64 : int'($urandom_range(1, 64)), rand_feat(),
              int'($urandom_range(0, 2)), 1'b0, 0, 0, '0, w);
    end
    sel = 1'b0;
  endtask

  task automatic test_random();
    int w, c;
    sel = 1'b0;
    for (int j = 0; j < 8; j++) begin
      fill_rand();
      c = (j == 0) ? 64 : (j == 1) ? 1 : int'($urandom_range(0, 64));
      run_job($sformatf("rand%0d", j), int'($urandom_range(0, 63)), c, rand_feat(),
              int'($urandom_range(0, 3)), 1'b0, 0, 0, '0, w);
    end
  endtask

  initial begin
    for (int a = 0; a < 64; a++) rom[a] = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_wrap_negative();
    test_count_zero();
    test_back_to_back();
    test_reset_mid_issue();
    test_overflow();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/conv_sched.md
Name: conv_sched

Overview:
- Job scheduler in front of the conv PIM crossbar array.
- Accepts one job at a time: an input feature vector, a base crossbar address and a row count.
- Issues one address per cycle to the array, captures each ADC result after the fixed array latency, and accumulates the results into a signed sum.
- Returns the sum through a valid/ready result port; sits between the layer sequencer and the conv instance.

Parameters:
- INPUT_SIZE, 34, width of the feature vector driven to the array.
- DEPTH, 6, crossbar address width; the array holds 2^DEPTH rows.
- ADC_P, 8, width of the array output, signed two's complement.
- PIM_LAT, 1, cycles from pim_en=1 to a valid pim_out; legal range 1..7.
- ACC_W, 16, accumulator/result width; must be >= ADC_P.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- job_valid  in  1  job request
- job_ready  out  1  scheduler can accept a job
- job_feature  in  INPUT_SIZE  feature vector for the whole job
- job_base  in  DEPTH  first crossbar address
- job_count  in  DEPTH+1  rows to read, 0..2^DEPTH
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts the result
- res_data  out  ACC_W  signed accumulated sum
- res_ovf  out  1  accumulator overflowed during the job
- pim_en  out  1  array enable
- pim_addr  out  DEPTH  array address
- pim_feature  out  INPUT_SIZE  array feature input
- pim_out  in  ADC_P  array result
- busy  out  1  high when state != IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - job_ready=1; res_valid=0, res_data=0, res_ovf=0, pim_en=0, pim_addr=0, pim_feature=0, busy=0.
  - Delay line, accumulator and counters are cleared.
  - Reset mid-job abandons the job; no result is produced.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: job_ready=1. On job_valid&&job_ready in cycle t:
  - Latch feature, base and count; clear accumulator and res_ovf.
  - If count=0, go to DONE (res_valid=1 at t+1, res_data=0).
  - Otherwise go to ISSUE.
- ISSUE (cycles t+1..t+N):
  - pim_en=1, pim_addr=(base+k) mod 2^DEPTH for k=0..N-1; the address wraps, with no error.
  - pim_feature holds the latched feature for the entire job.
  - After the N-th issue, go to DRAIN.
- Delay line: a PIM_LAT-deep shift register of issue flags. When the flag emerges, pim_out is sampled and accumulated, so issue k is sampled in cycle t+1+k+PIM_LAT.
- Arithmetic: pim_out is sign-extended to ACC_W and added. Overflow handling depends on CONV_SCHED_SAT_EN (below).
- DRAIN: pim_en=0, pim_addr holds its last value. When the final sample has been taken, go to DONE.
- DONE: res_valid=1; res_data and res_ovf are stable until res_valid&&res_ready.
  - On the handshake, go to IDLE; job_ready rises in the next cycle.
  - Accept-to-res_valid latency is N+PIM_LAT+1 cycles.
- job_ready=0 in every state except IDLE. There is no job pipelining; the next job is accepted no earlier than the cycle after the result handshake.
- res_ready is ignored outside DONE. Changes on job_* while busy are ignored.
- Issue throughput: one address per cycle, with no bubbles inside a job.

Optional Feature:
- Macro: CONV_SCHED_SAT_EN.
- Defined: each accumulate saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. res_ovf is sticky-set on any clip in the job.
- Undefined: two's-complement wrap. res_ovf is still sticky-set on signed overflow, and res_data is the wrapped value.

Decomposition:
- Package conv_pkg:
  - State enum conv_sched_state_t {IDLE, ISSUE, DRAIN, DONE}.
  - Parameter defaults CONV_INPUT_SIZE, CONV_DEPTH, CONV_ADC_P.
  - A sign-extend function.
- Sub-module conv_sched_acc: ACC_W accumulator with clear, add-enable, sign-extend, saturate/wrap (under the macro) and sticky overflow flag.
- The FSM, address counter and delay line stay in conv_sched.

Test Plan:
- Basic job: base=3, count=4, PIM model returns addr*2 (6,8,10,12) at PIM_LAT=1. Expect:
  - pim_addr 3,4,5,6 on consecutive cycles.
  - res_data=36, res_ovf=0, res_valid 6 cycles after accept.
- Wrap and negatives: DEPTH=6, base=62, count=4, model returns -1 per row. Expect addresses 62,63,0,1 and res_data=-4 (0xFFFC).
- Overflow: ACC_W=8, model returns 127, count=3.
  - With SAT_EN: res_data=127, res_ovf=1.
  - Without SAT_EN: res_data=0x7D (381 mod 256 = 125), res_ovf=1.
- count=0: accept -> res_valid next cycle, res_data=0, pim_en never asserted.
- Backpressure: hold res_ready=0 for 5 cycles in DONE, with job_valid=1 held throughout. Expect:
  - res_data stable and job_ready=0 during the stall.
  - After the handshake, job_ready=1 in the next cycle and the next job is accepted.
- Reset mid-ISSUE at k=2 of count=8. Expect outputs at reset values immediately; no res_valid after release; a fresh job completes normally.
